pipe_stage_buf: RTL and testbench

Parametrised pipeline stage buffer for the in-order core. It replaces fixed per-stage latches with a DEPTH-entry FIFO that uses a valid/ready handshake on both sides. It supports flush with a programmable post-flush drop shadow, a generalisation of the two-cycle flush bubbling used in the fetch/decode path. It sits between any two pipeline stages, for example fetch→decode or memory-response→writeback.

---
 rtl/pipe_stage_buf_if.sv | 12 +
 rtl/pipe_stage_buf.sv | 137 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/data bundle for one side of a pipe_stage_buf.
// The master drives valid and data and the slave drives ready.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry circular FIFO placed between two pipeline stages.
// Both sides use a valid/ready handshake. A flush empties the buffer. After a
// flush, a drop shadow of FLUSH_SHADOW cycles discards every accepted input.
// Optional build macro PIPE_STAGE_BUF_STATS_EN adds two saturating 32-bit
// counters: stall_cycles and drop_count.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       DEPTH        = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE    = '0,
  parameter int unsigned       FLUSH_SHADOW = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  pipe_stage_buf_if.slave              in_if,
  pipe_stage_buf_if.master             out_if,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         shadow_active
`ifdef PIPE_STAGE_BUF_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  drop_count
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SH_W  = 4;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [SH_W-1:0]   shadow_cnt, shadow_nxt;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic wr_en;
  logic rd_en;
  logic drop;

  // DEPTH may not be a power of two, so the wrap uses an explicit compare.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1))
      return '0;
    else
      return p + PTR_W'(1);
  endfunction

  // Handshake flags. in_ready depends only on registered occupancy, so there
  // is no combinational path from out_ready.
  assign in_ready      = (count != CNT_W'(DEPTH));
  assign out_valid     = (count != '0);
  assign shadow_active = (shadow_cnt != '0);

  assign accept = in_if.valid && in_ready;
  assign wr_en  = accept && !flush && !shadow_active;
  assign rd_en  = out_valid && out_if.ready && !flush;
  assign drop   = accept && (flush || shadow_active);

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_valid ? mem[rd_ptr] : NOP_VALUE;

  // Next-state: flush wins over read/write and restarts the shadow timer.
  always_comb begin
    count_nxt  = count;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    shadow_nxt = shadow_cnt;
    if (flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      shadow_nxt = SH_W'(FLUSH_SHADOW);
    end else begin
      if (shadow_active)
        shadow_nxt = shadow_cnt - SH_W'(1);
      if (wr_en)
        wr_ptr_nxt = next_ptr(wr_ptr);
      if (rd_en)
        rd_ptr_nxt = next_ptr(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      shadow_cnt <= '0;
    end else begin
      count      <= count_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      shadow_cnt <= shadow_nxt;
    end
  end

  // Payload storage. It has no reset because out_data is masked to NOP_VALUE when the buffer is empty.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= in_if.data;
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  // Saturating stall and drop counters. Only reset clears them. Flush does not.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cycles <= '0;
      drop_count   <= '0;
    end else begin
      if (out_valid && !out_if.ready && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (drop && (drop_count != 32'hFFFF_FFFF))
        drop_count <= drop_count + 32'd1;
    end
  end
`endif

  // Invariants: occupancy is bounded, the buffer is empty during the shadow,
  // and a stalled head entry holds its value.
  a_count_bound : assert property (@(posedge clk) disable iff (!rstn)
    count <= CNT_W'(DEPTH));
  a_shadow_empty : assert property (@(posedge clk) disable iff (!rstn)
    shadow_active |-> (count == '0));
  a_head_stable : assert property (@(posedge clk) disable iff (!rstn)
    (out_valid && !out_if.ready && !flush) |=> $stable(out_if.data));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf. Two instances receive the same stimulus:
//   A: DEPTH=2, FLUSH_SHADOW=2, NOP_VALUE=0
//   B: DEPTH=3, FLUSH_SHADOW=0, NOP_VALUE=32'hDEADBEEF
// The directed tests use A, plus B for the case with no shadow. A random phase
// compares both instances against a queue-level reference model.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;

  logic [1:0]  cnt_a, cnt_b;
  logic        sh_a, sh_b;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [31:0] stall_a, drop_a, stall_b, drop_b;
`endif

  int vectors = 0;
  int errors  = 0;

  pipe_stage_buf_if #(.DATA_W(32)) in_a ();
  pipe_stage_buf_if #(.DATA_W(32)) out_a ();
  pipe_stage_buf_if #(.DATA_W(32)) in_b ();
  pipe_stage_buf_if #(.DATA_W(32)) out_b ();

  assign in_a.valid  = in_valid;
  assign in_a.data   = in_data;
  assign out_a.ready = out_ready;
  assign in_b.valid  = in_valid;
  assign in_b.data   = in_data;
  assign out_b.ready = out_ready;

  pipe_stage_buf #(.DATA_W(32), .DEPTH(2), .NOP_VALUE(32'h0), .FLUSH_SHADOW(2)) dut_a (
    .clk(clk), .rstn(rstn), .in_if(in_a), .out_if(out_a), .flush(flush),
    .count(cnt_a), .shadow_active(sh_a)
`ifdef PIPE_STAGE_BUF_STATS_EN
    , .stall_cycles(stall_a), .drop_count(drop_a)
`endif
  );

  pipe_stage_buf #(.DATA_W(32), .DEPTH(3), .NOP_VALUE(32'hDEADBEEF), .FLUSH_SHADOW(0)) dut_b (
    .clk(clk), .rstn(rstn), .in_if(in_b), .out_if(out_b), .flush(flush),
    .count(cnt_b), .shadow_active(sh_b)
`ifdef PIPE_STAGE_BUF_STATS_EN
    , .stall_cycles(stall_b), .drop_count(drop_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of held entries plus a shadow countdown.
  int unsigned      m_cnt   [2];
  int unsigned      m_sh    [2];
  logic [31:0]      m_q     [2][4];
  longint unsigned  m_stall [2];
  longint unsigned  m_drop  [2];

  function automatic int unsigned m_depth(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int unsigned m_shadow_len(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] m_nop(input int i);
    return (i == 0) ? 32'h0 : 32'hDEADBEEF;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_sh[i] = 0; m_stall[i] = 0; m_drop[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic iv, input logic [31:0] d,
                            input logic ordy, input logic fl, input logic rs);
    logic can_take, pop, push;
    if (!rs) begin
      m_cnt[i] = 0; m_sh[i] = 0; m_stall[i] = 0; m_drop[i] = 0;
      return;
    end
    can_take = (m_cnt[i] != m_depth(i));
    if (m_cnt[i] != 0 && !ordy && m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
    if (iv && can_take && (fl || m_sh[i] != 0) && m_drop[i] < 64'hFFFF_FFFF) m_drop[i]++;
    if (fl) begin
      m_cnt[i] = 0;
      m_sh[i]  = m_shadow_len(i);
    end else begin
      pop  = (m_cnt[i] != 0) && ordy;
      push = iv && can_take && (m_sh[i] == 0);
      if (m_sh[i] != 0) m_sh[i]--;
      if (pop) begin
        for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
        m_cnt[i]--;
      end
      if (push) begin
        m_q[i][m_cnt[i]] = d;
        m_cnt[i]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    vectors++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
    vectors++; if (out_a.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_a.valid); end
    vectors++; if (out_a.data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_a.data); end
    vectors++; if (in_a.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_a.ready); end
    vectors++; if (sh_a !== 1'b0) begin errors++; $display("FAIL reset_shadow: got %b want 0", sh_a); end
    vectors++; if (out_b.data !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_nop_b: got %h want deadbeef", out_b.data); end
    rstn = 1'b1;
  endtask

  task automatic test_fill_drain();
    in_valid = 1'b1; in_data = 32'hA1; out_ready = 1'b0;
    tick();
    vectors++; if (cnt_a !== 2'd1) begin errors++; $display("FAIL fill_count1: got %0d want 1", cnt_a); end
    vectors++; if (out_a.data !== 32'hA1) begin errors++; $display("FAIL fill_head1: got %h want a1", out_a.data); end
    in_data = 32'hB2;
    tick();
    vectors++; if (cnt_a !== 2'd2) begin errors++; $display("FAIL fill_count2: got %0d want 2", cnt_a); end
    vectors++; if (in_a.ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", in_a.ready); end
    in_valid = 1'b0;
    tick();
    vectors++; if (out_a.data !== 32'hA1) begin errors++; $display("FAIL fill_hold: got %h want a1", out_a.data); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_a.data !== 32'hB2) begin errors++; $display("FAIL drain_second: got %h want b2", out_a.data); end
    tick();
    vectors++; if (out_a.valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b want 0", out_a.valid); end
    vectors++; if (out_a.data !== 32'h0) begin errors++; $display("FAIL drain_nop: got %h want 0", out_a.data); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_data = 32'hA1; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      in_data = 32'hC3 + 32'(k); out_ready = 1'b1;
      tick();
      vectors++; if (cnt_a !== 2'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want 1", k, cnt_a); end
      vectors++; if (out_a.data !== 32'hC3 + 32'(k)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, out_a.data, 32'hC3 + 32'(k)); end
    end
    in_valid = 1'b0;
    tick();
    vectors++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", cnt_a); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_shadow();
    in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
    tick();
    in_data = 32'h22;
    tick();
    flush = 1'b1; in_data = 32'hD4;
    tick();
    flush = 1'b0;
    vectors++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", cnt_a); end
    vectors++; if (out_a.valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_a.valid); end
    vectors++; if (sh_a !== 1'b1) begin errors++; $display("FAIL flush_shadow_on: got %b want 1", sh_a); end
    in_data = 32'hE5;
    tick();
    vectors++; if (cnt_a !== 2'd0 || sh_a !== 1'b1) begin errors++; $display("FAIL shadow_drop1: got count %0d shadow %b want 0/1", cnt_a, sh_a); end
    in_data = 32'hF6;
    tick();
    vectors++; if (cnt_a !== 2'd0 || sh_a !== 1'b0) begin errors++; $display("FAIL shadow_drop2: got count %0d shadow %b want 0/0", cnt_a, sh_a); end
    in_data = 32'h17;
    tick();
    vectors++; if (cnt_a !== 2'd1 || out_a.data !== 32'h17) begin errors++; $display("FAIL post_shadow_push: got count %0d data %h want 1/17", cnt_a, out_a.data); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush_reload();
    flush = 1'b1;
    tick();
    vectors++; if (sh_a !== 1'b1) begin errors++; $display("FAIL reload_first: got %b want 1", sh_a); end
    tick();
    flush = 1'b0;
    vectors++; if (sh_a !== 1'b1) begin errors++; $display("FAIL reload_after_reflush: got %b want 1", sh_a); end
    tick();
    vectors++; if (sh_a !== 1'b1) begin errors++; $display("FAIL reload_second_cycle: got %b want 1", sh_a); end
    tick();
    vectors++; if (sh_a !== 1'b0) begin errors++; $display("FAIL reload_expire: got %b want 0", sh_a); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b0;
    tick();
    in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    vectors++; if (cnt_a !== 2'd2) begin errors++; $display("FAIL mid_prefill: got %0d want 2", cnt_a); end
    do_reset();
    vectors++; if (cnt_a !== 2'd0 || out_a.valid !== 1'b0 || out_a.data !== 32'h0 || in_a.ready !== 1'b1)
      begin errors++; $display("FAIL mid_reset: got count %0d valid %b data %h ready %b want 0/0/0/1", cnt_a, out_a.valid, out_a.data, in_a.ready); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_reset();
    vectors++; if (sh_a !== 1'b0) begin errors++; $display("FAIL mid_shadow_reset: got %b want 0", sh_a); end
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1; in_data = 32'h5A;
    tick();
    in_valid = 1'b0;
    vectors++; if (cnt_b !== 2'd1 || out_b.data !== 32'h5A || sh_b !== 1'b0)
      begin errors++; $display("FAIL no_shadow_push: got count %0d data %h shadow %b want 1/5a/0", cnt_b, out_b.data, sh_b); end
  endtask

`ifdef PIPE_STAGE_BUF_STATS_EN
  task automatic test_stats();
    idle_inputs();
    do_reset();
    in_valid = 1'b1; in_data = 32'h33;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    vectors++; if (stall_a !== 32'd3) begin errors++; $display("FAIL stats_stall: got %0d want 3", stall_a); end
    vectors++; if (drop_a !== 32'd2) begin errors++; $display("FAIL stats_drop: got %0d want 2", drop_a); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (stall_a !== 32'd3 || drop_a !== 32'd2) begin errors++; $display("FAIL stats_flush_keep: got %0d/%0d want 3/2", stall_a, drop_a); end
    do_reset();
    vectors++; if (stall_a !== 32'd0 || drop_a !== 32'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d want 0/0", stall_a, drop_a); end
  endtask
`endif

  task automatic test_random();
    logic        o_valid, o_ready, o_sh;
    logic [31:0] o_data, e_data;
    logic [1:0]  o_cnt;
    idle_inputs();
    do_reset();
    model_clear();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rstn      = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < 2; i++) begin
        o_valid = (i == 0) ? out_a.valid : out_b.valid;
        o_data  = (i == 0) ? out_a.data  : out_b.data;
        o_ready = (i == 0) ? in_a.ready  : in_b.ready;
        o_cnt   = (i == 0) ? cnt_a       : cnt_b;
        o_sh    = (i == 0) ? sh_a        : sh_b;
        e_data  = (m_cnt[i] != 0) ? m_q[i][0] : m_nop(i);
        vectors++; if (o_cnt !== 2'(m_cnt[i])) begin errors++; $display("FAIL rnd_count[%0d] cyc %0d: got %0d want %0d", i, n, o_cnt, m_cnt[i]); end
        vectors++; if (o_valid !== (m_cnt[i] != 0)) begin errors++; $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", i, n, o_valid, m_cnt[i] != 0); end
        vectors++; if (o_data !== e_data) begin errors++; $display("FAIL rnd_data[%0d] cyc %0d: got %h want %h", i, n, o_data, e_data); end
        vectors++; if (o_ready !== (m_cnt[i] != m_depth(i))) begin errors++; $display("FAIL rnd_in_ready[%0d] cyc %0d: got %b want %b", i, n, o_ready, m_cnt[i] != m_depth(i)); end
        vectors++; if (o_sh !== (m_sh[i] != 0)) begin errors++; $display("FAIL rnd_shadow[%0d] cyc %0d: got %b want %b", i, n, o_sh, m_sh[i] != 0); end
`ifdef PIPE_STAGE_BUF_STATS_EN
        vectors++; if (((i == 0) ? stall_a : stall_b) !== 32'(m_stall[i])) begin errors++; $display("FAIL rnd_stall[%0d] cyc %0d: got %0d want %0d", i, n, (i == 0) ? stall_a : stall_b, m_stall[i]); end
        vectors++; if (((i == 0) ? drop_a : drop_b) !== 32'(m_drop[i])) begin errors++; $display("FAIL rnd_drop[%0d] cyc %0d: got %0d want %0d", i, n, (i == 0) ? drop_a : drop_b, m_drop[i]); end
`endif
      end
      tick();
      for (int i = 0; i < 2; i++) model_step(i, in_valid, in_data, out_ready, flush, rstn);
    end
    rstn = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush_shadow();
    test_flush_reload();
    test_reset_mid();
`ifdef PIPE_STAGE_BUF_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
